// File: rtl/layer_priority_mixer_pkg.sv
// Shared types and helpers for the layer priority mixer: packed RGB layout
// and the collision popcount test.
package mixer_pkg;

  localparam int CH_W    = 4;
  localparam int COLOR_W = 3 * CH_W;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // Packed colour is {R,G,B} with red in the MSBs.
  function automatic rgb_t rgb_unpack(input logic [COLOR_W-1:0] c);
    rgb_t px;
    px.r = c[3*CH_W-1 -: CH_W];
    px.g = c[2*CH_W-1 -: CH_W];
    px.b = c[CH_W-1 -: CH_W];
    return px;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_ge2(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/layer_priority_mixer_if.sv
// Pixel bus between the object drawers, the mixer and the DAC side.
// The master drives layer data and reads the mixed pixel; the mixer is the slave.
interface layer_priority_mixer_if #(
  parameter int NUM_LAYERS = 4,
  parameter int CH_W       = 4
);
  localparam int COLOR_W = 3 * CH_W;
  localparam int TOP_W   = $clog2(NUM_LAYERS + 1);

  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]         layer_draw;
  logic [NUM_LAYERS-1:0]         layer_en;
  logic [COLOR_W-1:0]            bg_rgb;
  logic                          pix_valid;
  logic                          start_of_frame;

  logic [CH_W-1:0]               Red_level;
  logic [CH_W-1:0]               Green_level;
  logic [CH_W-1:0]               Blue_level;
  logic                          pix_valid_out;
  logic [TOP_W-1:0]              top_layer;
  logic [NUM_LAYERS-1:0]         collision_mask;

  modport master (
    output layer_rgb, layer_draw, layer_en, bg_rgb, pix_valid, start_of_frame,
    input  Red_level, Green_level, Blue_level, pix_valid_out, top_layer, collision_mask
  );

  modport slave (
    input  layer_rgb, layer_draw, layer_en, bg_rgb, pix_valid, start_of_frame,
    output Red_level, Green_level, Blue_level, pix_valid_out, top_layer, collision_mask
  );
endinterface

// File: rtl/layer_priority_mixer_prio_enc.sv
// Combinational lowest-index-first priority encoder; idx = N when nothing is set.
module layer_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0]               qual,
  output logic [$clog2(N+1)-1:0]     idx,
  output logic                       any
);
  localparam int IW = $clog2(N + 1);

  always_comb begin
    idx = IW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (qual[i]) begin
        idx = IW'(i);
      end
    end
  end

  assign any = |qual;
endmodule

// File: rtl/layer_priority_mixer.sv
// N-layer pixel mixer: stage 1 qualifies draw requests, stage 2 picks the winner,
// blanks inactive pixels and accumulates the per-frame collision mask.
module layer_priority_mixer #(
  parameter int                  NUM_LAYERS = 4,
  parameter int                  CH_W       = mixer_pkg::CH_W,
  parameter int                  COLOR_W    = 3 * CH_W,
  parameter bit                  KEY_EN     = 1'b1,
  parameter logic [COLOR_W-1:0]  TRANS_KEY  = COLOR_W'(12'h0F0)
) (
  input  logic                   clk,
  input  logic                   reset,
  layer_priority_mixer_if.slave  bus
);
  import mixer_pkg::*;

  localparam int TOP_W = $clog2(NUM_LAYERS + 1);

  logic [NUM_LAYERS-1:0]         qual_next;
  logic [NUM_LAYERS-1:0]         qual_reg;
  logic [NUM_LAYERS*COLOR_W-1:0] rgb_s1_reg;
  logic [COLOR_W-1:0]            bg_s1_reg;
  logic                          valid_s1_reg;
  logic                          sof_s1_reg;

  logic [TOP_W-1:0]              win_idx;
  logic                          win_any;
  logic [COLOR_W-1:0]            sel_rgb_next;
  logic [TOP_W-1:0]              top_next;
  rgb_t                          px_next;
  logic [NUM_LAYERS-1:0]         contrib_next;

  logic [CH_W-1:0]               red_reg;
  logic [CH_W-1:0]               green_reg;
  logic [CH_W-1:0]               blue_reg;
  logic                          valid_out_reg;
  logic [TOP_W-1:0]              top_reg;
  logic [NUM_LAYERS-1:0]         live_reg;
  logic [NUM_LAYERS-1:0]         collision_reg;

  // A keyed or disabled layer is treated exactly as if it did not draw.
  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_qual
      logic [COLOR_W-1:0] rgb_i;
      logic               keyed_i;
      assign rgb_i         = bus.layer_rgb[gi*COLOR_W +: COLOR_W];
      assign keyed_i       = KEY_EN && (rgb_i == TRANS_KEY);
      assign qual_next[gi] = bus.layer_draw[gi] & bus.layer_en[gi] & ~keyed_i;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      qual_reg     <= '0;
      rgb_s1_reg   <= '0;
      bg_s1_reg    <= '0;
      valid_s1_reg <= 1'b0;
      sof_s1_reg   <= 1'b0;
    end else begin
      qual_reg     <= qual_next;
      rgb_s1_reg   <= bus.layer_rgb;
      bg_s1_reg    <= bus.bg_rgb;
      valid_s1_reg <= bus.pix_valid;
      sof_s1_reg   <= bus.start_of_frame;
    end
  end

  layer_prio_enc #(
    .N (NUM_LAYERS)
  ) u_enc (
    .qual (qual_reg),
    .idx  (win_idx),
    .any  (win_any)
  );

  always_comb begin
    sel_rgb_next = bg_s1_reg;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (win_any && (win_idx == TOP_W'(i))) begin
        sel_rgb_next = rgb_s1_reg[i*COLOR_W +: COLOR_W];
      end
    end
    if (!valid_s1_reg) begin
      sel_rgb_next = '0;
    end
    top_next = valid_s1_reg ? win_idx : TOP_W'(NUM_LAYERS);
  end

  assign px_next      = rgb_unpack(sel_rgb_next);
  assign contrib_next = (valid_s1_reg && popcount_ge2(32'(qual_reg))) ? qual_reg : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      red_reg       <= '0;
      green_reg     <= '0;
      blue_reg      <= '0;
      valid_out_reg <= 1'b0;
      top_reg       <= TOP_W'(NUM_LAYERS);
      live_reg      <= '0;
      collision_reg <= '0;
    end else begin
      red_reg       <= px_next.r;
      green_reg     <= px_next.g;
      blue_reg      <= px_next.b;
      valid_out_reg <= valid_s1_reg;
      top_reg       <= top_next;
      // The SOF pixel opens the new frame, so its overlap seeds the fresh live mask.
      if (sof_s1_reg) begin
        collision_reg <= live_reg;
        live_reg      <= contrib_next;
      end else begin
        live_reg      <= live_reg | contrib_next;
      end
    end
  end

  assign bus.Red_level      = red_reg;
  assign bus.Green_level    = green_reg;
  assign bus.Blue_level     = blue_reg;
  assign bus.pix_valid_out  = valid_out_reg;
  assign bus.top_layer      = top_reg;
  assign bus.collision_mask = collision_reg;

endmodule

// File: tb/tb_layer_priority_mixer.sv
// Scoreboard bench for layer_priority_mixer: a behavioural model pushes the
// expected pixel when stimulus is driven, and it is popped two clocks later.
module tb_layer_priority_mixer;

  localparam int NL = 4;

  typedef struct {
    logic [11:0] rgb;
    logic        valid;
    logic [2:0]  top;
    logic [3:0]  cmask;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  bit   verbose;
  exp_t q[$];
  logic [3:0] m_live;
  logic [3:0] m_latched;

  layer_priority_mixer_if #(.NUM_LAYERS(NL), .CH_W(4)) bus ();

  layer_priority_mixer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One pixel per call: compare what is due now, then drive the next pixel.
  task automatic cycle(input logic rst, input logic [47:0] rgb, input logic [3:0] draw,
                       input logic [3:0] en, input logic [11:0] bg,
                       input logic valid, input logic sof);
    exp_t       e;
    logic [3:0] qual;
    logic [3:0] contrib;
    logic [11:0] c;
    @(negedge clk);
    if (reset) begin
      check("rst_red",   32'(bus.Red_level),      32'd0);
      check("rst_green", 32'(bus.Green_level),    32'd0);
      check("rst_blue",  32'(bus.Blue_level),     32'd0);
      check("rst_valid", 32'(bus.pix_valid_out),  32'd0);
      check("rst_top",   32'(bus.top_layer),      32'd4);
      check("rst_cmask", 32'(bus.collision_mask), 32'd0);
    end else if (q.size() == 2) begin
      e = q.pop_front();
      check("red",   32'(bus.Red_level),      32'(e.rgb[11:8]));
      check("green", 32'(bus.Green_level),    32'(e.rgb[7:4]));
      check("blue",  32'(bus.Blue_level),     32'(e.rgb[3:0]));
      check("valid", 32'(bus.pix_valid_out),  32'(e.valid));
      check("top",   32'(bus.top_layer),      32'(e.top));
      check("cmask", 32'(bus.collision_mask), 32'(e.cmask));
    end
    reset              = rst;
    bus.layer_rgb      = rgb;
    bus.layer_draw     = draw;
    bus.layer_en       = en;
    bus.bg_rgb         = bg;
    bus.pix_valid      = valid;
    bus.start_of_frame = sof;
    if (rst) begin
      q.delete();
      m_live    = '0;
      m_latched = '0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        c       = rgb[i*12 +: 12];
        qual[i] = draw[i] & en[i] & (c != 12'h0F0);
      end
      e.top = 3'd4;
      e.rgb = bg;
      for (int i = NL - 1; i >= 0; i--) begin
        if (qual[i]) begin
          e.top = 3'(i);
          e.rgb = rgb[i*12 +: 12];
        end
      end
      if (!valid) begin
        e.rgb = '0;
        e.top = 3'd4;
      end
      e.valid = valid;
      contrib = (valid && ($countones(qual) >= 2)) ? qual : 4'b0;
      if (sof) begin
        m_latched = m_live;
        m_live    = contrib;
      end else begin
        m_live = m_live | contrib;
      end
      e.cmask = m_latched;
      q.push_back(e);
    end
    if (verbose) begin
      $display("pix rst=%0d draw=%b en=%b valid=%0d sof=%0d rgb=%h bg=%h", rst, draw, en, valid, sof, rgb, bg);
    end
  endtask

  initial begin
    logic [47:0] rgb;
    logic [3:0]  draw;
    logic [3:0]  en;
    logic        valid;
    logic        sof;
    n_vec   = 0;
    n_err   = 0;
    verbose = 1'b1;
    m_live    = '0;
    m_latched = '0;
    reset              = 1'b1;
    bus.layer_rgb      = {12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC};
    bus.layer_draw     = 4'hF;
    bus.layer_en       = 4'hF;
    bus.bg_rgb         = 12'h777;
    bus.pix_valid      = 1'b1;
    bus.start_of_frame = 1'b1;

    // Reset held with draws active
    for (int i = 0; i < 3; i++) cycle(1'b1, {12'hFFF, 12'hEEE, 12'hDDD, 12'hCCC}, 4'hF, 4'hF, 12'h777, 1'b1, 1'b1);

    // Priority, key/enable, blanking
    cycle(1'b0, {12'h000, 12'h456, 12'h123, 12'h000}, 4'b0110, 4'hF, 12'h000, 1'b1, 1'b0);
    cycle(1'b0, {12'h000, 12'h000, 12'hABC, 12'h0F0}, 4'b0011, 4'hF, 12'h321, 1'b1, 1'b0);
    cycle(1'b0, {12'h000, 12'h000, 12'hABC, 12'h0F0}, 4'b0011, 4'b1101, 12'h321, 1'b1, 1'b0);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'hF, 4'hF, 12'hFFF, 1'b0, 1'b0);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'h0, 4'h0, 12'h5A5, 1'b1, 1'b0);

    // Collision: frame A overlaps on 1010, frame B has none
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b0001, 4'hF, 12'h000, 1'b1, 1'b1);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b1010, 4'hF, 12'h000, 1'b1, 1'b0);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b0100, 4'hF, 12'h000, 1'b1, 1'b0);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b0001, 4'hF, 12'h000, 1'b1, 1'b1);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b1000, 4'hF, 12'h000, 1'b1, 1'b0);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b0010, 4'hF, 12'h000, 1'b1, 1'b0);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b0000, 4'hF, 12'h000, 1'b1, 1'b1);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b0000, 4'hF, 12'h000, 1'b1, 1'b0);
    cycle(1'b0, {12'h111, 12'h222, 12'h333, 12'h444}, 4'b0000, 4'hF, 12'h000, 1'b1, 1'b0);

    // Random throughput run with keyed pixels, enable changes, blanking and SOF overlaps
    verbose = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < NL; i++) begin
        rgb[i*12 +: 12] = ($urandom_range(0, 7) == 0) ? 12'h0F0 : 12'($urandom);
      end
      draw  = 4'($urandom);
      en    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      valid = ($urandom_range(0, 7) != 0);
      sof   = (n % 50 == 0);
      if (n % 100 == 0) begin
        draw  = 4'b0101;
        en    = 4'hF;
        valid = 1'b1;
        rgb[11:0]  = 12'h1A2;
        rgb[35:24] = 12'h3B4;
      end
      if (n % 150 == 0) valid = 1'b0;
      cycle((n >= 5000 && n < 5002) ? 1'b1 : 1'b0, rgb, draw, en, 12'($urandom), valid, sof);
    end
    cycle(1'b0, '0, 4'h0, 4'hF, 12'h000, 1'b0, 1'b0);
    cycle(1'b0, '0, 4'h0, 4'hF, 12'h000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
